mem_rd: RTL and testbench

- Load-side counterpart of the store data/mask generator in the Excute stage.
- Accepts a load op from Excute and issues a line read to the data cache over a valid/ready request channel.
- Waits for the cache response, then selects and zero- or sign-extends the byte, halfword or word.
- Holds the result for writeback under a valid/ready handshake; one load in flight at a time.

---
 rtl/mem_rd_pkg.sv | 33 +++
 rtl/mem_rd_extract.sv | 42 ++++
 rtl/mem_rd.sv | 126 ++++++++++++
 tb/tb_mem_rd.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rd_pkg.sv
// Shared types and constants for the load-side cache read unit (mem_rd).
package mem_rd_pkg;

  typedef logic [31:0] cpu_t;

  // Bit positions inside the 6-bit load-op vector from Excute.
  localparam int unsigned LD_EN = 5;
  localparam int unsigned LD_W  = 4;
  localparam int unsigned LD_HU = 3;
  localparam int unsigned LD_H  = 2;
  localparam int unsigned LD_BU = 1;
  localparam int unsigned LD_B  = 0;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } state_e;

  // Follows the same Lw > Lhu/Lh priority as the extractor.
  function automatic logic is_misaligned(input logic [4:0] ld_type, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    if (ld_type[LD_W]) begin
      mis = (lo != 2'b00);
    end else if (ld_type[LD_HU] || ld_type[LD_H]) begin
      mis = lo[0];
    end
    return mis;
  endfunction

endpackage

// File: rtl/mem_rd_extract.sv
// Selects the addressed word from a cache line and extracts / extends the
// byte, halfword or word according to the captured load type.
module mem_rd_extract
  import mem_rd_pkg::*;
#(
  parameter int unsigned CACHE_WIDTHE = 6
) (
  input  logic [2**CACHE_WIDTHE-1:0] line_i,
  input  logic [CACHE_WIDTHE-4:0]    offset_i,
  input  logic [4:0]                 ld_type_i,
  output logic [31:0]                data_o
);

  localparam int unsigned OffW = CACHE_WIDTHE - 3;

  logic [OffW+2:0] word_sh;
  logic [31:0]     word;
  logic [7:0]      byte_v;
  logic [15:0]     half;

  // Bit offset of the addressed 32-bit lane within the line.
  assign word_sh = {offset_i[OffW-1:2], 5'b00000};
  assign word    = line_i[word_sh +: 32];
  assign byte_v  = word[{offset_i[1:0], 3'b000} +: 8];
  assign half    = offset_i[1] ? word[31:16] : word[15:0];

  always_comb begin
    data_o = '0;
    if (ld_type_i[LD_W]) begin
      data_o = word;
    end else if (ld_type_i[LD_HU]) begin
      data_o = {16'h0000, half};
    end else if (ld_type_i[LD_H]) begin
      data_o = {{16{half[15]}}, half};
    end else if (ld_type_i[LD_BU]) begin
      data_o = {24'h000000, byte_v};
    end else if (ld_type_i[LD_B]) begin
      data_o = {{24{byte_v[7]}}, byte_v};
    end
  end

endmodule

// File: rtl/mem_rd.sv
// Load unit: one load in flight, cache line read over valid/ready, result held for writeback.
// Optional MEM_RD_MISALIGN_EXC_EN: misaligned Lh/Lhu/Lw skip the cache and flag oMemRdExc.
module mem_rd
  import mem_rd_pkg::*;
#(
  parameter int unsigned CACHE_WIDTHE  = 6,
  parameter int unsigned CACHE_DEEPTHE = 6,
  parameter int unsigned TAG_W         = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [5:0]                iMemRdOpEn,
  input  logic [31:0]               iMemRdAddr,
  input  logic [TAG_W-1:0]          iMemRdTag,
  output logic                      oMemRdBusy,
  output logic                      oDcacheReqValid,
  input  logic                      iDcacheReqReady,
  output logic [CACHE_DEEPTHE-1:0]  oDcacheReqAddr,
  input  logic                      iDcacheRspValid,
  input  logic [2**CACHE_WIDTHE-1:0] iDcacheRspData,
  output logic                      oMemRdValid,
  input  logic                      iWbReady,
  output logic [31:0]               oMemRdData,
  output logic [TAG_W-1:0]          oMemRdTag,
  output logic                      oMemRdExc
);

  localparam int unsigned OffW  = CACHE_WIDTHE - 3;
  localparam int unsigned AddrW = OffW + CACHE_DEEPTHE;

  state_e             state_q;
  logic [4:0]         type_q;
  logic [AddrW-1:0]   addr_q;
  logic [TAG_W-1:0]   tag_q;
  logic [31:0]        data_q;
  logic               busy_q, req_valid_q, valid_q, exc_q;
  logic [31:0]        ext_data;
  logic               load_start, start_misal;
  logic               unused_addr;

  // A new load is taken in IDLE, or in the DONE cycle whose result is consumed.
  assign load_start = iMemRdOpEn[LD_EN] &&
                      ((state_q == StIdle) || ((state_q == StDone) && iWbReady));

`ifdef MEM_RD_MISALIGN_EXC_EN
  assign start_misal = is_misaligned(iMemRdOpEn[4:0], iMemRdAddr[1:0]);
`else
  assign start_misal = 1'b0;
`endif

  assign unused_addr = ^iMemRdAddr[31:AddrW];

  mem_rd_extract #(
    .CACHE_WIDTHE(CACHE_WIDTHE)
  ) u_extract (
    .line_i    (iDcacheRspData),
    .offset_i  (addr_q[OffW-1:0]),
    .ld_type_i (type_q),
    .data_o    (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      type_q      <= '0;
      addr_q      <= '0;
      tag_q       <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      req_valid_q <= 1'b0;
      valid_q     <= 1'b0;
      exc_q       <= 1'b0;
    end else if (load_start) begin
      type_q <= iMemRdOpEn[4:0];
      addr_q <= iMemRdAddr[AddrW-1:0];
      tag_q  <= iMemRdTag;
      busy_q <= 1'b1;
      if (start_misal) begin
        state_q     <= StDone;
        req_valid_q <= 1'b0;
        valid_q     <= 1'b1;
        exc_q       <= 1'b1;
        data_q      <= '0;
      end else begin
        state_q     <= StReq;
        req_valid_q <= 1'b1;
        valid_q     <= 1'b0;
        exc_q       <= 1'b0;
      end
    end else begin
      case (state_q)
        StReq: begin
          if (iDcacheReqReady) begin
            state_q     <= StWait;
            req_valid_q <= 1'b0;
          end
        end
        StWait: begin
          if (iDcacheRspValid) begin
            state_q <= StDone;
            data_q  <= ext_data;
            valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (iWbReady) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            exc_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign oMemRdBusy      = busy_q;
  assign oDcacheReqValid = req_valid_q;
  assign oDcacheReqAddr  = addr_q[AddrW-1:OffW];
  assign oMemRdValid     = valid_q;
  assign oMemRdData      = data_q;
  assign oMemRdTag       = tag_q;
  assign oMemRdExc       = exc_q;

endmodule

// File: tb/tb_mem_rd.sv
// Self-checking bench for mem_rd: cache model, scoreboard of expected results,
// directed handshake / reset cases plus a short random load mix.
module tb_mem_rd;

  localparam int unsigned TagW = 5;

  typedef struct packed {
    logic [31:0]     data;
    logic [TagW-1:0] tag;
    logic            exc;
  } res_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [5:0]      iMemRdOpEn = '0;
  logic [31:0]     iMemRdAddr = '0;
  logic [TagW-1:0] iMemRdTag = '0;
  logic            oMemRdBusy, oDcacheReqValid, oMemRdValid, oMemRdExc;
  logic            iDcacheReqReady = 1'b1;
  logic [5:0]      oDcacheReqAddr;
  logic            iDcacheRspValid = 1'b0;
  logic [63:0]     iDcacheRspData = '0;
  logic            iWbReady = 1'b1;
  logic [31:0]     oMemRdData;
  logic [TagW-1:0] oMemRdTag;

  res_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_valid_seen = 0;
  logic [63:0] line_mem [64];
  logic        ready_en = 1'b1, rsp_en = 1'b1, spur = 1'b0, pend = 1'b0;
  logic [5:0]  pend_addr = '0;

  always #5 clk = ~clk;

  mem_rd #(.CACHE_WIDTHE(6), .CACHE_DEEPTHE(6), .TAG_W(TagW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .iMemRdOpEn      (iMemRdOpEn),
    .iMemRdAddr      (iMemRdAddr),
    .iMemRdTag       (iMemRdTag),
    .oMemRdBusy      (oMemRdBusy),
    .oDcacheReqValid (oDcacheReqValid),
    .iDcacheReqReady (iDcacheReqReady),
    .oDcacheReqAddr  (oDcacheReqAddr),
    .iDcacheRspValid (iDcacheRspValid),
    .iDcacheRspData  (iDcacheRspData),
    .oMemRdValid     (oMemRdValid),
    .iWbReady        (iWbReady),
    .oMemRdData      (oMemRdData),
    .oMemRdTag       (oMemRdTag),
    .oMemRdExc       (oMemRdExc)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [4:0] op, input logic [31:0] addr,
                                           input logic [63:0] line);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = addr[2] ? line[63:32] : line[31:0];
    case (addr[1:0])
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = addr[1] ? w[31:16] : w[15:0];
    if (op[4]) return w;
    if (op[3]) return {16'h0, h};
    if (op[2]) return {{16{h[15]}}, h};
    if (op[1]) return {24'h0, b};
    if (op[0]) return {{24{b[7]}}, b};
    return 32'h0;
  endfunction

  function automatic logic ref_misal(input logic [4:0] op, input logic [31:0] addr);
`ifdef MEM_RD_MISALIGN_EXC_EN
    if (op[4]) return addr[1:0] != 2'b00;
    if (op[3] || op[2]) return addr[0];
    return 1'b0;
`else
    return (op[0] && !op[0]) || (addr[0] && !addr[0]);
`endif
  endfunction

  // Cache model: handshake sampled mid-cycle, response driven one cycle later.
  always @(negedge clk) begin
    if (oDcacheReqValid && iDcacheReqReady) begin
      pend      = 1'b1;
      pend_addr = oDcacheReqAddr;
    end
  end

  always @(posedge clk) begin
    #2;
    iDcacheReqReady = ready_en;
    if (pend && rsp_en) begin
      iDcacheRspValid = 1'b1;
      iDcacheRspData  = line_mem[pend_addr];
      pend            = 1'b0;
    end else begin
      iDcacheRspValid = spur;
    end
  end

  // Scoreboard consumer.
  always @(negedge clk) begin
    res_t e;
    if (oMemRdValid) begin
      n_valid_seen++;
      if (iWbReady) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(oMemRdData), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("result_data", 64'(oMemRdData), 64'(e.data));
          check("result_tag", 64'(oMemRdTag), 64'(e.tag));
          check("result_exc", 64'(oMemRdExc), 64'(e.exc));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input logic [4:0] op, input logic [31:0] addr,
                            input logic [TagW-1:0] tag, input bit push);
    res_t e;
    iMemRdOpEn = {1'b1, op};
    iMemRdAddr = addr;
    iMemRdTag  = tag;
    if (push) begin
      e.exc  = ref_misal(op, addr);
      e.data = e.exc ? 32'h0 : ref_load(op, addr, line_mem[addr[8:3]]);
      e.tag  = tag;
      exp_q.push_back(e);
    end
    step();
    iMemRdOpEn = '0;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    for (int i = 1; i <= max && n == 0; i++) begin
      @(negedge clk);
      if (oMemRdValid) n = i;
    end
  endtask

  // Best-case load: request seen in the first cycle, result 3 cycles after enable.
  task automatic load(input logic [4:0] op, input logic [31:0] addr, input logic [TagW-1:0] tag);
    int  n;
    bit  mis;
    mis = ref_misal(op, addr);
    drive_load(op, addr, tag, 1'b1);
    @(negedge clk);
    if (mis) begin
      check("misal_no_req", 64'(oDcacheReqValid), 64'd0);
      check("misal_valid", 64'(oMemRdValid), 64'd1);
    end else begin
      check("req_valid", 64'(oDcacheReqValid), 64'd1);
      check("req_addr", 64'(oDcacheReqAddr), 64'(addr[8:3]));
      wait_valid(40, n);
      check("latency", 64'(n + 1), 64'd3);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int          n, n0;
    logic [4:0]  op;
    logic [31:0] addr;

    for (int i = 0; i < 64; i++) line_mem[i] = '0;

    repeat (2) @(negedge clk);
    check("rst_busy", 64'(oMemRdBusy), 64'd0);
    check("rst_req_valid", 64'(oDcacheReqValid), 64'd0);
    check("rst_valid", 64'(oMemRdValid), 64'd0);
    check("rst_data", 64'(oMemRdData), 64'd0);
    check("rst_tag", 64'(oMemRdTag), 64'd0);
    check("rst_exc", 64'(oMemRdExc), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    line_mem[0] = 64'h0000_0000_80FF_1234;
    load(5'b00001, 32'h0000_0003, 5'd3);
    load(5'b00010, 32'h0000_0003, 5'd4);
    load(5'b01000, 32'h0000_0002, 5'd5);
    load(5'b00100, 32'h0000_0002, 5'd6);
    line_mem[0] = 64'hDEAD_BEEF_0000_0001;
    load(5'b10000, 32'h0000_0004, 5'd7);
    line_mem[53] = 64'hCAFE_F00D_1357_9BDF;
    load(5'b10000, 32'hABCD_E1AC, 5'd8);
    load(5'b00000, 32'h0000_0008, 5'd9);
    load(5'b11111, 32'h0000_0000, 5'd10);

    for (int i = 0; i < 8; i++) begin
      op   = 5'(1 << $urandom_range(0, 4));
      addr = $urandom;
      if (op[4]) addr[1:0] = 2'b00;
      if (op[3] || op[2]) addr[0] = 1'b0;
      line_mem[addr[8:3]] = {$urandom, $urandom};
      load(op, addr, TagW'($urandom_range(0, 31)));
    end

    line_mem[0] = 64'hDEAD_BEEF_0000_0001;
`ifdef MEM_RD_MISALIGN_EXC_EN
    load(5'b10000, 32'h0000_0001, 5'd11);
    load(5'b00100, 32'h0000_0003, 5'd12);
`else
    load(5'b10000, 32'h0000_0005, 5'd11);
    load(5'b01000, 32'h0000_0003, 5'd12);
`endif

    // Request stall then writeback stall.
    ready_en = 1'b0;
    iWbReady = 1'b0;
    line_mem[2] = 64'h1111_2222_3333_4444;
    drive_load(5'b10000, 32'h0000_0014, 5'd13, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_req_valid", 64'(oDcacheReqValid), 64'd1);
      check("stall_req_addr", 64'(oDcacheReqAddr), 64'd2);
      if (i == 3) begin
        @(posedge clk);
        #1;
        ready_en = 1'b1;
      end
    end
    wait_valid(10, n);
    check("stall_result_seen", 64'(n != 0), 64'd1);
    for (int k = 0; k < 3; k++) begin
      check("hold_valid", 64'(oMemRdValid), 64'd1);
      check("hold_data", 64'(oMemRdData), 64'h1111_2222);
      check("hold_tag", 64'(oMemRdTag), 64'd13);
      if (k < 2) @(negedge clk);
    end
    step();
    iWbReady = 1'b1;
    step();
    step();

    // Back-to-back: second load enabled in the consuming DONE cycle.
    line_mem[0] = 64'h0000_0000_0000_00A5;
    line_mem[1] = 64'h0000_0000_0000_0080;
    drive_load(5'b00010, 32'h0000_0000, 5'd14, 1'b1);
    step();
    step();
    drive_load(5'b00001, 32'h0000_0008, 5'd15, 1'b1);
    @(negedge clk);
    check("b2b_busy", 64'(oMemRdBusy), 64'd1);
    check("b2b_req_valid", 64'(oDcacheReqValid), 64'd1);
    check("b2b_valid_low", 64'(oMemRdValid), 64'd0);
    wait_valid(10, n);
    check("b2b_latency", 64'(n), 64'd2);
    step();
    step();

    // Spurious response in IDLE.
    n0   = n_valid_seen;
    spur = 1'b1;
    step();
    spur = 1'b0;
    repeat (3) step();
    check("spurious_valid", 64'(n_valid_seen - n0), 64'd0);
    check("spurious_busy", 64'(oMemRdBusy), 64'd0);

    // Reset while waiting for the response.
    rsp_en = 1'b0;
    drive_load(5'b10000, 32'h0000_0000, 5'd14, 1'b0);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    check("wrst_busy", 64'(oMemRdBusy), 64'd0);
    check("wrst_valid", 64'(oMemRdValid), 64'd0);
    check("wrst_data", 64'(oMemRdData), 64'd0);
    check("wrst_tag", 64'(oMemRdTag), 64'd0);
    step();
    rst_n  = 1'b1;
    rsp_en = 1'b1;
    n0     = n_valid_seen;
    repeat (4) step();
    check("wrst_late_rsp_valid", 64'(n_valid_seen - n0), 64'd0);
    check("wrst_late_busy", 64'(oMemRdBusy), 64'd0);
    check("wrst_late_data", 64'(oMemRdData), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
